// File: rtl/debounce_filter.sv
// Per-line debounce with registered rise/fall strobes and a busy flag.
// Define DEBOUNCE_FILTER_SYNC_EN to add a two-flop synchronizer ahead of the filter.
module debounce_filter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             d_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o
);

    // Bit 1 is the committed level and bit 0 marks a qualification in progress.
    localparam logic [1:0] ST_LO  = 2'd0;
    localparam logic [1:0] CHK_HI = 2'd1;
    localparam logic [1:0] ST_HI  = 2'd2;
    localparam logic [1:0] CHK_LO = 2'd3;

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             rise_r, rise_s;
    logic             fall_r, fall_s;
    logic             samp_s;
    logic [CNT_W:0]   need_s;
    logic [CNT_W:0]   next_cnt_s;
    logic             need_one_s;
    logic             commit_s;

`ifdef DEBOUNCE_FILTER_SYNC_EN
    logic sync1_r, sync2_r;

    // Two-flop synchronizer, clocked every cycle regardless of en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= d_i;
            sync2_r <= sync1_r;
        end
    end

    assign samp_s = sync2_r;
`else
    assign samp_s = d_i;
`endif

    // One extra bit keeps cnt+1 from wrapping when thresh_i is all ones.
    assign need_s     = (thresh_i == {CNT_W{1'b0}}) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, thresh_i};
    assign next_cnt_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign need_one_s = (need_s == {{CNT_W{1'b0}}, 1'b1});
    assign commit_s   = (next_cnt_s >= need_s);

    // Next-state, counter and strobe decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        if (clr_i) begin
            state_s = ST_LO;
            cnt_s   = {CNT_W{1'b0}};
        end else if (en_i) begin
            case (state_r)
                ST_LO: begin
                    if (samp_s) begin
                        if (need_one_s) begin
                            state_s = ST_HI;
                            rise_s  = 1'b1;
                        end else begin
                            state_s = CHK_HI;
                            cnt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_s = ST_LO;
                    end
                end
                CHK_HI: begin
                    if (!samp_s) begin
                        state_s = ST_LO;
                        cnt_s   = {CNT_W{1'b0}};
                    end else if (commit_s) begin
                        state_s = ST_HI;
                        cnt_s   = {CNT_W{1'b0}};
                        rise_s  = 1'b1;
                    end else begin
                        cnt_s   = next_cnt_s[CNT_W-1:0];
                    end
                end
                ST_HI: begin
                    if (!samp_s) begin
                        if (need_one_s) begin
                            state_s = ST_LO;
                            fall_s  = 1'b1;
                        end else begin
                            state_s = CHK_LO;
                            cnt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_s = ST_HI;
                    end
                end
                CHK_LO: begin
                    if (samp_s) begin
                        state_s = ST_HI;
                        cnt_s   = {CNT_W{1'b0}};
                    end else if (commit_s) begin
                        state_s = ST_LO;
                        cnt_s   = {CNT_W{1'b0}};
                        fall_s  = 1'b1;
                    end else begin
                        cnt_s   = next_cnt_s[CNT_W-1:0];
                    end
                end
                default: begin
                    state_s = ST_LO;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
        end
    end

    // Filter state and strobe registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_LO;
            cnt_r   <= {CNT_W{1'b0}};
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    assign level_o = state_r[1];
    assign busy_o  = state_r[0];
    assign rise_o  = rise_r;
    assign fall_o  = fall_r;

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter: a run-length reference model queues expected
// outputs per clock and a monitor compares them against the DUT.
module tb_debounce_filter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] thresh_i = 8'd0;
    logic       d_i = 1'b0;
    logic       level_o, rise_o, fall_o, busy_o;

    int tests = 0;
    int fails = 0;

    // Expected outputs packed as {level, rise, fall, busy}.
    logic [3:0] sb_q[$];

    // Reference model: committed level, length of the current mismatch run,
    // and the input delay line used when the synchronizer is compiled in.
    logic m_level = 1'b0;
    int   m_run   = 0;
    logic m_sy1   = 1'b0;
    logic m_sy2   = 1'b0;

    debounce_filter #(.CNT_W(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .clr_i   (clr_i),
        .thresh_i(thresh_i),
        .d_i     (d_i),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got {level,rise,fall,busy}=%b, expected %b", name, $time, got, exp);
        end
    endtask

    // Drive one clock's inputs and queue the response expected after the next rising edge.
    task automatic step(input logic en, input logic clr, input logic [7:0] th, input logic d);
        logic s;
        logic rise, fall;
        int   n;
        @(negedge clk_i);
        rst_i    = 1'b0;
        en_i     = en;
        clr_i    = clr;
        thresh_i = th;
        d_i      = d;
`ifdef DEBOUNCE_FILTER_SYNC_EN
        s     = m_sy2;
        m_sy2 = m_sy1;
        m_sy1 = d;
`else
        s = d;
`endif
        n    = (th == 8'd0) ? 1 : int'(th);
        rise = 1'b0;
        fall = 1'b0;
        if (clr) begin
            m_level = 1'b0;
            m_run   = 0;
        end else if (en) begin
            if (s != m_level) begin
                m_run++;
                if (m_run >= n) begin
                    m_level = s;
                    rise    = s;
                    fall    = ~s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        sb_q.push_back({m_level, rise, fall, (m_run != 0)});
    endtask

    // Assert reset between edges and require all outputs to clear without a clock.
    task automatic async_reset();
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        d_i   = 1'b0;
        #1;
        check("async_reset", {level_o, rise_o, fall_o, busy_o}, 4'b0000);
        m_level = 1'b0;
        m_run   = 0;
        m_sy1   = 1'b0;
        m_sy2   = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_hold", {level_o, rise_o, fall_o, busy_o}, 4'b0000);
    endtask

    // Monitor: one comparison per clock whenever an expectation is pending.
    initial begin
        logic [3:0] exp;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                check("cycle", {level_o, rise_o, fall_o, busy_o}, exp);
            end
        end
    end

    initial begin
        logic       d;
        logic [7:0] th;
        #1;
        check("reset_state", {level_o, rise_o, fall_o, busy_o}, 4'b0000);
        repeat (2) @(negedge clk_i);

        // Clean rise and fall with N=4.
        repeat (7) step(1'b1, 1'b0, 8'd4, 1'b1);
        repeat (7) step(1'b1, 1'b0, 8'd4, 1'b0);

        // Glitch shorter than N is rejected.
        repeat (3) step(1'b1, 1'b0, 8'd4, 1'b1);
        repeat (4) step(1'b1, 1'b0, 8'd4, 1'b0);

        // N=1 through thresh 0 and thresh 1: every toggle commits.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'd0, i[0]);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'd1, ~i[0]);
        repeat (3) step(1'b1, 1'b0, 8'd1, 1'b0);

        // Enable pulsed one cycle in four.
        for (int i = 0; i < 20; i++) step((i % 4) == 0, 1'b0, 8'd3, 1'b1);
        for (int i = 0; i < 20; i++) step((i % 4) == 0, 1'b0, 8'd3, 1'b0);

        // Clear has priority and produces no fall strobe, then re-qualify.
        repeat (5) step(1'b1, 1'b0, 8'd2, 1'b1);
        step(1'b1, 1'b1, 8'd2, 1'b1);
        repeat (5) step(1'b1, 1'b0, 8'd2, 1'b1);

        // Threshold lowered mid-check commits immediately.
        repeat (5) step(1'b1, 1'b0, 8'd6, 1'b0);
        step(1'b1, 1'b0, 8'd2, 1'b0);
        repeat (2) step(1'b1, 1'b0, 8'd2, 1'b0);

        // Maximum qualify time with thresh all ones.
        repeat (258) step(1'b1, 1'b0, 8'd255, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'd255, 1'b0);

        // Reset while level is high.
        repeat (4) step(1'b1, 1'b0, 8'd1, 1'b1);
        async_reset();
        repeat (4) step(1'b1, 1'b0, 8'd2, 1'b0);

        // Randomized sticky input, random enable, occasional clear and threshold change.
        d  = 1'b0;
        th = 8'd3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5, 0) == 0) d = ~d;
            if ($urandom_range(49, 0) == 0) th = 8'($urandom_range(6, 0));
            step($urandom_range(3, 0) != 0, $urandom_range(63, 0) == 0, th, d);
            if (i == 700) begin
                async_reset();
                d = 1'b0;
            end
        end

        repeat (3) @(posedge clk_i);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
